// File: rtl/csu.sv
// Control/status unit: sequences pipeline flushes, icache/TLB maintenance and
// fetch-PC redirects between the writeback/execute stages and the IFU.
module csu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cs_flush,
  input  logic [31:0] cs_dnpc,
  input  logic        flush_icache,
  input  logic        flush_tlb,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        pipe_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        fetch_hold,
  output logic        icache_inv_req,
  input  logic        icache_inv_done,
  output logic        tlb_inv_req,
  input  logic        tlb_inv_done
);

  // state    | meaning
  // BOOT     | just out of reset, loading RESET_PC as the redirect target
  // IDLE     | normal fetch, watching for commit flushes and branch redirects
  // INV_IC   | waiting for the icache invalidate to complete
  // INV_TLB  | waiting for the TLB invalidate to complete
  // REDIRECT | offering the captured target PC to the IFU
  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_INV_IC,
    S_INV_TLB,
    S_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic        fic_q, fic_d;
  logic        ftlb_q, ftlb_d;
  logic        rv_q, ic_req_q, tlb_req_q, hold_q;
  logic [31:0] rpc_q;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    fic_d      = fic_q;
    ftlb_d     = ftlb_q;
    pipe_flush = 1'b0;
    case (state_q)
      S_BOOT: begin
        tgt_d   = RESET_PC;
        state_d = S_REDIRECT;
      end
      S_IDLE: begin
        // Commit-side flush wins over a same-cycle branch redirect.
        if (cs_flush) begin
          pipe_flush = 1'b1;
          tgt_d      = cs_dnpc;
          fic_d      = flush_icache;
          ftlb_d     = flush_tlb;
          if (flush_icache)   state_d = S_INV_IC;
          else if (flush_tlb) state_d = S_INV_TLB;
          else                state_d = S_REDIRECT;
        end else if (br_valid) begin
          pipe_flush = 1'b1;
          tgt_d      = br_target;
          fic_d      = 1'b0;
          ftlb_d     = 1'b0;
          state_d    = S_REDIRECT;
        end
      end
      S_INV_IC: begin
        if (icache_inv_done) state_d = ftlb_q ? S_INV_TLB : S_REDIRECT;
      end
      S_INV_TLB: begin
        if (tlb_inv_done) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_BOOT;
      tgt_q     <= 32'h0;
      fic_q     <= 1'b0;
      ftlb_q    <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= 32'h0;
      ic_req_q  <= 1'b0;
      tlb_req_q <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      fic_q     <= fic_d;
      ftlb_q    <= ftlb_d;
      rv_q      <= (state_d == S_REDIRECT);
      rpc_q     <= (state_d == S_REDIRECT) ? tgt_d : 32'h0;
      ic_req_q  <= (state_d == S_INV_IC);
      tlb_req_q <= (state_d == S_INV_TLB);
      hold_q    <= (state_d != S_IDLE);
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign icache_inv_req = ic_req_q;
  assign tlb_inv_req    = tlb_req_q;
  assign fetch_hold     = hold_q;

endmodule

// File: tb/tb_csu.sv
// Self-checking bench for csu: directed scenarios plus randomized traffic
// against a queue-of-pending-phases reference model.
module tb_csu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int PH_IC = 0, PH_TLB = 1, PH_REDIR = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic cs_flush = 1'b0, flush_icache = 1'b0, flush_tlb = 1'b0, br_valid = 1'b0;
  logic [31:0] cs_dnpc = '0, br_target = '0;
  logic redirect_ready = 1'b0, icache_inv_done = 1'b0, tlb_inv_done = 1'b0;
  logic pipe_flush, redirect_valid, fetch_hold, icache_inv_req, tlb_inv_req;
  logic [31:0] redirect_pc;

  always #5 clock = ~clock;

  csu #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .flush_icache(flush_icache), .flush_tlb(flush_tlb),
    .br_valid(br_valid), .br_target(br_target),
    .pipe_flush(pipe_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .fetch_hold(fetch_hold),
    .icache_inv_req(icache_inv_req), .icache_inv_done(icache_inv_done),
    .tlb_inv_req(tlb_inv_req), .tlb_inv_done(tlb_inv_done)
  );

  // Reference model: a boot flag plus a queue of outstanding phases.
  bit          m_boot;
  int          m_q[$];
  logic [31:0] m_tgt;
  logic        exp_pf, exp_rv, exp_ic, exp_tlb, exp_hold;
  logic [31:0] exp_pc;
  logic [36:0] exp_v, act_v;
  int          n_vec = 0, n_err = 0;

  assign act_v = {pipe_flush, redirect_valid, redirect_pc, icache_inv_req, tlb_inv_req, fetch_hold};

  task automatic model_eval();
    bit busy;
    busy     = m_boot || (m_q.size() != 0);
    exp_hold = busy;
    exp_pf   = !busy && (cs_flush || br_valid);
    exp_ic   = !m_boot && m_q.size() != 0 && m_q[0] == PH_IC;
    exp_tlb  = !m_boot && m_q.size() != 0 && m_q[0] == PH_TLB;
    exp_rv   = !m_boot && m_q.size() != 0 && m_q[0] == PH_REDIR;
    exp_pc   = exp_rv ? m_tgt : 32'h0;
    exp_v    = {exp_pf, exp_rv, exp_pc, exp_ic, exp_tlb, exp_hold};
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) begin
      m_boot = 1; m_q.delete(); m_tgt = 32'h0;
    end else if (m_boot) begin
      m_boot = 0; m_q.push_back(PH_REDIR); m_tgt = RST_PC;
    end else if (m_q.size() == 0) begin
      if (cs_flush) begin
        m_tgt = cs_dnpc;
        if (flush_icache) m_q.push_back(PH_IC);
        if (flush_tlb)    m_q.push_back(PH_TLB);
        m_q.push_back(PH_REDIR);
      end else if (br_valid) begin
        m_tgt = br_target;
        m_q.push_back(PH_REDIR);
      end
    end else begin
      case (m_q[0])
        PH_IC:   if (icache_inv_done) void'(m_q.pop_front());
        PH_TLB:  if (tlb_inv_done)    void'(m_q.pop_front());
        default: if (redirect_ready)  void'(m_q.pop_front());
      endcase
    end
    #1;
  endtask

  task automatic clear_inputs();
    cs_flush = 0; flush_icache = 0; flush_tlb = 0; br_valid = 0;
    cs_dnpc = '0; br_target = '0; icache_inv_done = 0; tlb_inv_done = 0;
  endtask

  task automatic test_reset();
    reset = 0; clear_inputs(); redirect_ready = 1;
    tick(); tick();
    #1; model_eval();
    n_vec++;
    if (act_v !== 37'h1) begin
      n_err++; $display("FAIL reset_outputs act=%h exp=%h", act_v, 37'h1);
    end
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL reset_model act=%h exp=%h", act_v, exp_v);
    end
  endtask

  task automatic test_boot();
    int rv_cycles;
    reset = 1; redirect_ready = 1; rv_cycles = 0;
    for (int k = 0; k < 4; k++) begin
      #1; model_eval();
      if (redirect_valid) rv_cycles++;
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL boot_cycle%0d act=%h exp=%h", k, act_v, exp_v);
      end
      if (k == 1) begin
        n_vec++;
        if (!(redirect_valid === 1'b1 && redirect_pc === RST_PC)) begin
          n_err++; $display("FAIL boot_redirect rv=%b pc=%h exp rv=1 pc=%h", redirect_valid, redirect_pc, RST_PC);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (fetch_hold !== 1'b0) begin
          n_err++; $display("FAIL boot_hold_release act=%b exp=0", fetch_hold);
        end
      end
      tick();
    end
    n_vec++;
    if (rv_cycles != 1) begin
      n_err++; $display("FAIL boot_rv_cycles act=%0d exp=1", rv_cycles);
    end
  endtask

  task automatic test_plain_flush();
    redirect_ready = 1; cs_flush = 1; cs_dnpc = 32'h8000_0104;
    #1; model_eval();
    n_vec++;
    if (pipe_flush !== 1'b1 || act_v !== exp_v) begin
      n_err++; $display("FAIL plain_flush_pf act=%h exp=%h", act_v, exp_v);
    end
    tick(); clear_inputs();
    #1; model_eval();
    n_vec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0104 || act_v !== exp_v) begin
      n_err++; $display("FAIL plain_flush_redirect act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_fence_satp();
    int ic_n, tlb_n, rv_n;
    bit idle_seen, hold_bad;
    ic_n = 0; tlb_n = 0; rv_n = 0; idle_seen = 0; hold_bad = 0;
    redirect_ready = 1; cs_flush = 1; flush_icache = 1; flush_tlb = 1; cs_dnpc = 32'h8000_2000;
    #1; model_eval();
    n_vec++;
    if (pipe_flush !== 1'b1 || act_v !== exp_v) begin
      n_err++; $display("FAIL fence_pf act=%h exp=%h", act_v, exp_v);
    end
    tick(); clear_inputs();
    for (int k = 0; k < 20 && !idle_seen; k++) begin
      icache_inv_done = icache_inv_req && (ic_n == 2);
      tlb_inv_done    = tlb_inv_req && (tlb_n == 1);
      if (icache_inv_req) ic_n++;
      if (tlb_inv_req) tlb_n++;
      if (redirect_valid) rv_n++;
      #1; model_eval();
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL fence_cycle%0d act=%h exp=%h", k, act_v, exp_v);
      end
      if (fetch_hold === 1'b0) idle_seen = 1;
      else tick();
    end
    clear_inputs();
    n_vec++;
    if (ic_n != 3 || tlb_n != 2 || rv_n != 1 || !idle_seen) begin
      n_err++; $display("FAIL fence_counts act ic=%0d tlb=%0d rv=%0d idle=%0d exp 3 2 1 1", ic_n, tlb_n, rv_n, idle_seen);
    end
  endtask

  task automatic test_collision();
    redirect_ready = 1; cs_flush = 1; cs_dnpc = 32'h100; br_valid = 1; br_target = 32'h200;
    #1; model_eval();
    tick(); clear_inputs();
    #1; model_eval();
    n_vec++;
    if (redirect_pc !== 32'h100 || act_v !== exp_v) begin
      n_err++; $display("FAIL collision act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] t;
    t = $urandom;
    redirect_ready = 0; br_valid = 1; br_target = t;
    tick();
    for (int k = 0; k < 4; k++) begin
      br_valid = k[0] ? 1'b0 : 1'b1; br_target = $urandom;
      cs_flush = $urandom_range(0, 1); cs_dnpc = $urandom;
      #1; model_eval();
      n_vec++;
      if (redirect_valid !== 1'b1 || redirect_pc !== t || pipe_flush !== 1'b0 || act_v !== exp_v) begin
        n_err++; $display("FAIL backpressure_cycle%0d act=%h exp=%h", k, act_v, exp_v);
      end
      tick();
    end
    clear_inputs(); redirect_ready = 1;
    tick();
    #1; model_eval();
    n_vec++;
    if (fetch_hold !== 1'b0 || act_v !== exp_v) begin
      n_err++; $display("FAIL backpressure_release act=%h exp=%h", act_v, exp_v);
    end
  endtask

  task automatic test_reset_mid_inv();
    redirect_ready = 1; cs_flush = 1; flush_icache = 1;
    tick(); clear_inputs();
    #1; model_eval();
    n_vec++;
    if (icache_inv_req !== 1'b1 || act_v !== exp_v) begin
      n_err++; $display("FAIL midinv_req act=%h exp=%h", act_v, exp_v);
    end
    reset = 0;
    tick();
    #1; model_eval();
    n_vec++;
    if (icache_inv_req !== 1'b0 || fetch_hold !== 1'b1 || act_v !== exp_v) begin
      n_err++; $display("FAIL midinv_drop act=%h exp=%h", act_v, exp_v);
    end
    reset = 1;
    tick();
    #1; model_eval();
    n_vec++;
    if (redirect_valid !== 1'b1 || redirect_pc !== RST_PC || act_v !== exp_v) begin
      n_err++; $display("FAIL midinv_reboot act=%h exp=%h", act_v, exp_v);
    end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      reset           = ($urandom_range(0, 99) != 0);
      cs_flush        = ($urandom_range(0, 3) == 0);
      br_valid        = ($urandom_range(0, 3) == 0);
      flush_icache    = $urandom_range(0, 1);
      flush_tlb       = $urandom_range(0, 1);
      cs_dnpc         = $urandom;
      br_target       = $urandom;
      redirect_ready  = $urandom_range(0, 1);
      icache_inv_done = ($urandom_range(0, 2) == 0);
      tlb_inv_done    = ($urandom_range(0, 2) == 0);
      #1; model_eval();
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL random_cycle%0d act=%h exp=%h", k, act_v, exp_v);
      end
      tick();
    end
    reset = 1; clear_inputs();
  endtask

  initial begin
    m_boot = 1; m_tgt = '0;
    test_reset();
    test_boot();
    test_plain_flush();
    test_fence_satp();
    test_collision();
    test_backpressure();
    test_reset_mid_inv();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
